ysyx_22040386_pipe_reg: RTL and testbench

YSYX_22040386_PIPE_REG -- requirements
Module: ysyx_22040386_pipe_reg

---
 rtl/ysyx_22040386_pipe_reg_pkg.sv | 13 +
 rtl/ysyx_22040386_pipe_reg.sv | 109 ++++++++++
 tb/tb_ysyx_22040386_pipe_reg.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040386_pipe_reg_pkg.sv
// Shared definitions for the ysyx_22040386 pipeline register: occupancy width
// and the state encoding, which doubles as the occupancy count.
package ysyx_22040386_pipe_reg_pkg;

  localparam int PR_CNT_W = 2;

  typedef enum logic [PR_CNT_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } pr_state_e;

endpackage

// File: rtl/ysyx_22040386_pipe_reg.sv
// Valid/ready pipeline stage register: 2-entry skid buffer (SKID=1) or a
// single register with combinational ready (SKID=0), with a squash input.
module ysyx_22040386_pipe_reg
  import ysyx_22040386_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SKID   = 1
) (
  input  logic                i_PR_clk,
  input  logic                i_PR_rst,
  input  logic                i_PR_flush,
  input  logic                i_PR_in_valid,
  output logic                o_PR_in_ready,
  input  logic [DATA_W-1:0]   i_PR_in_data,
  output logic                o_PR_out_valid,
  input  logic                i_PR_out_ready,
  output logic [DATA_W-1:0]   o_PR_out_data,
  output logic [PR_CNT_W-1:0] o_PR_count
);

  pr_state_e          state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic               in_ready_s;
  logic               out_valid_s;
  logic               in_fire_s;
  logic               out_fire_s;

  // Handshake decode; the skid variant keeps ready a pure function of state.
  always_comb begin
    out_valid_s = (state_q != ST_EMPTY);
    if (SKID != 0) begin
      in_ready_s = (state_q != ST_FULL);
    end else begin
      in_ready_s = ~out_valid_s | i_PR_out_ready;
    end
    in_fire_s  = i_PR_in_valid & in_ready_s;
    out_fire_s = out_valid_s & i_PR_out_ready;
  end

  // Next-state and entry updates; flush squashes everything, including a same-cycle push.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_PR_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d = ST_HALF;
            main_d  = i_PR_in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (in_fire_s && out_fire_s) begin
            main_d = i_PR_in_data;
          end else if (in_fire_s) begin
            // Only reachable with a skid entry; the single-register variant
            // cannot accept while full unless downstream also drains.
            if (SKID != 0) begin
              state_d = ST_FULL;
              skid_d  = i_PR_in_data;
            end else begin
              main_d = i_PR_in_data;
            end
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_HALF;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_d = ST_HALF;
            main_d  = skid_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge i_PR_clk) begin
    if (i_PR_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign o_PR_in_ready  = in_ready_s;
  assign o_PR_out_valid = out_valid_s;
  assign o_PR_out_data  = main_q;
  assign o_PR_count     = state_q;

endmodule

// File: tb/tb_ysyx_22040386_pipe_reg.sv
// Bench for ysyx_22040386_pipe_reg: directed vector table on the skid variant,
// a replace/hold sequence on the single-register variant, and random traffic vs queue models.
module tb_ysyx_22040386_pipe_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = 64'd0;

  logic        in_ready1, out_valid1;
  logic [63:0] out_data1;
  logic [1:0]  count1;
  logic        in_ready0, out_valid0;
  logic [7:0]  out_data0;
  logic [1:0]  count0;

  int checks = 0;
  int failures = 0;

  logic [63:0] q1[$];
  logic [7:0]  q0[$];
  logic        z1, z0;   // entry registers known to be zero (just reset, nothing pushed)

  always #5 clk = ~clk;

  ysyx_22040386_pipe_reg #(.DATA_W(64), .SKID(1)) dut1 (
    .i_PR_clk(clk), .i_PR_rst(rst), .i_PR_flush(flush),
    .i_PR_in_valid(in_valid), .o_PR_in_ready(in_ready1), .i_PR_in_data(in_data),
    .o_PR_out_valid(out_valid1), .i_PR_out_ready(out_ready), .o_PR_out_data(out_data1),
    .o_PR_count(count1)
  );

  ysyx_22040386_pipe_reg #(.DATA_W(8), .SKID(0)) dut0 (
    .i_PR_clk(clk), .i_PR_rst(rst), .i_PR_flush(flush),
    .i_PR_in_valid(in_valid), .o_PR_in_ready(in_ready0), .i_PR_in_data(in_data[7:0]),
    .o_PR_out_valid(out_valid0), .i_PR_out_ready(out_ready), .o_PR_out_data(out_data0),
    .o_PR_count(count0)
  );

  typedef struct {
    logic        rst, flush, iv, ordy;
    logic [63:0] d;
    logic        e_rdy, e_v;
    logic [1:0]  e_cnt;
    logic        chk_d;
    logic [63:0] e_d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic od, logic [63:0] d,
                              logic er, logic ev, logic [1:0] ec, logic cd, logic [63:0] ed);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = od; v.d = d;
    v.e_rdy = er; v.e_v = ev; v.e_cnt = ec; v.chk_d = cd; v.e_d = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs with their queue models, then advance one clock and update the models.
  task automatic tick();
    logic r1, v1, r0, v0;
    #1;
    r1 = (q1.size() < 2);
    v1 = (q1.size() != 0);
    r0 = (q0.size() == 0) || out_ready;
    v0 = (q0.size() != 0);
    chk("m1_in_ready", {63'd0, in_ready1}, {63'd0, r1});
    chk("m1_out_valid", {63'd0, out_valid1}, {63'd0, v1});
    chk("m1_count", {62'd0, count1}, 64'(q1.size()));
    if (v1) chk("m1_out_data", out_data1, q1[0]);
    else if (z1) chk("m1_zero_data", out_data1, 64'd0);
    chk("m0_in_ready", {63'd0, in_ready0}, {63'd0, r0});
    chk("m0_out_valid", {63'd0, out_valid0}, {63'd0, v0});
    chk("m0_count", {62'd0, count0}, 64'(q0.size()));
    if (v0) chk("m0_out_data", {56'd0, out_data0}, {56'd0, q0[0]});
    else if (z0) chk("m0_zero_data", {56'd0, out_data0}, 64'd0);
    @(posedge clk);
    if (rst) begin
      q1.delete(); q0.delete(); z1 = 1'b1; z0 = 1'b1;
    end else if (flush) begin
      q1.delete(); q0.delete(); z1 = 1'b0; z0 = 1'b0;
    end else begin
      if (v1 && out_ready) void'(q1.pop_front());
      if (in_valid && r1) begin q1.push_back(in_data); z1 = 1'b0; end
      if (v0 && out_ready) void'(q0.pop_front());
      if (in_valid && r0) begin q0.push_back(in_data[7:0]); z0 = 1'b0; end
    end
    @(negedge clk);
  endtask

  initial begin
    z1 = 1'b0; z0 = 1'b0;
    // Initial reset: outputs are unknown before the first edge, so no checks yet.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    z1 = 1'b1; z0 = 1'b1;

    // Streaming, backpressure, flush, mid-operation reset on the skid variant.
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,64'h1, 1'b1,1'b0,2'd0,1'b1,64'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,64'h2, 1'b1,1'b1,2'd1,1'b1,64'h1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,64'h3, 1'b1,1'b1,2'd1,1'b1,64'h2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,64'h4, 1'b1,1'b1,2'd1,1'b1,64'h3));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,64'h0, 1'b1,1'b1,2'd1,1'b1,64'h4));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,64'h0, 1'b1,1'b1,2'd1,1'b1,64'h4));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,64'hA, 1'b1,1'b0,2'd0,1'b0,64'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,64'hB, 1'b1,1'b1,2'd1,1'b1,64'hA));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,64'hC, 1'b0,1'b1,2'd2,1'b1,64'hA));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,64'h0, 1'b0,1'b1,2'd2,1'b1,64'hA));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,64'h0, 1'b1,1'b1,2'd1,1'b1,64'hB));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,64'h0, 1'b1,1'b0,2'd0,1'b0,64'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,64'hA, 1'b1,1'b0,2'd0,1'b0,64'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,64'hB, 1'b1,1'b1,2'd1,1'b1,64'hA));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,64'hC, 1'b0,1'b1,2'd2,1'b1,64'hA));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,64'h0, 1'b1,1'b0,2'd0,1'b0,64'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,64'hD, 1'b1,1'b0,2'd0,1'b0,64'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1,64'hE, 1'b1,1'b1,2'd1,1'b1,64'hD));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,64'h0, 1'b1,1'b0,2'd0,1'b0,64'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,64'hA, 1'b1,1'b0,2'd0,1'b0,64'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,64'hB, 1'b1,1'b1,2'd1,1'b1,64'hA));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,64'h0, 1'b0,1'b1,2'd2,1'b1,64'hA));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,64'h0, 1'b1,1'b0,2'd0,1'b1,64'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,64'h5, 1'b1,1'b0,2'd0,1'b1,64'h0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,64'h0, 1'b1,1'b1,2'd1,1'b1,64'h5));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,64'h0, 1'b1,1'b0,2'd0,1'b0,64'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
      out_ready = tbl[i].ordy; in_data = tbl[i].d;
      #1;
      chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready1}, {63'd0, tbl[i].e_rdy});
      chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid1}, {63'd0, tbl[i].e_v});
      chk($sformatf("vec%0d_count", i), {62'd0, count1}, {62'd0, tbl[i].e_cnt});
      if (tbl[i].chk_d) chk($sformatf("vec%0d_out_data", i), out_data1, tbl[i].e_d);
      tick();
    end

    // Single-register variant: same-cycle replace, then hold under backpressure.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 64'd0;
    tick();
    rst = 1'b0; in_valid = 1'b1; in_data = 64'h11;
    tick();
    in_data = 64'h22; out_ready = 1'b1;
    #1;
    chk("s0_replace_ready", {63'd0, in_ready0}, 64'd1);
    chk("s0_before_replace", {56'd0, out_data0}, 64'h11);
    tick();
    in_data = 64'h33; out_ready = 1'b0;
    #1;
    chk("s0_hold_ready", {63'd0, in_ready0}, 64'd0);
    chk("s0_after_replace", {56'd0, out_data0}, 64'h22);
    tick();
    in_valid = 1'b0;
    #1;
    chk("s0_held", {56'd0, out_data0}, 64'h22);
    tick();

    // Random traffic against the queue models.
    for (int c = 0; c < 10000; c++) begin
      rst       = ($urandom_range(499, 0) == 0);
      flush     = ($urandom_range(19, 0) == 0);
      in_valid  = ($urandom_range(1, 0) == 1);
      out_ready = ($urandom_range(9, 0) < 6);
      in_data   = {$urandom(), $urandom()};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
